tx_stream_gate_stats: RTL and testbench

TX_STREAM_GATE_STATS -- requirements
Module: tx_stream_gate_stats

---
 rtl/tx_stream_gate_stats.sv | 165 ++++++++++++++++
 tb/tb_tx_stream_gate_stats.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_stream_gate_stats.sv
// Packet gate between the rate limiter and the MAC: forwards or drops whole packets
// through a registered AXI-Stream stage and keeps forwarded/dropped packet statistics.
module tx_stream_gate_stats #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                axi_aclk,
    input  logic                                axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    input  logic                                gate_en,
    input  logic                                clear_stats,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_count,
    output logic [2*C_S_AXI_DATA_WIDTH-1:0]     byte_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       drop_count,
    output logic [15:0]                         max_pkt_len
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int BEAT_W = $clog2(STRB_W + 1);
    localparam int CNT_W  = C_S_AXI_DATA_WIDTH;
    localparam int BYTE_W = 2 * C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {SOF, PASS, DROP} state_e;

    state_e                            state_q, state_d;
    logic [15:0]                       len_q, len_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_tstrb_q, m_tstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
    logic                              m_tvalid_q, m_tvalid_d;
    logic                              m_tlast_q, m_tlast_d;
    logic [CNT_W-1:0]                  pkt_q, pkt_d, drop_q, drop_d;
    logic [BYTE_W-1:0]                 byte_q, byte_d;
    logic [15:0]                       max_q, max_d;

    logic [BEAT_W-1:0] beat_bytes;
    logic [16:0]       len_sum;
    logic [15:0]       len_acc;
    logic              s_ready, s_fire, fwd, drop_beat;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < STRB_W; i++) begin
            beat_bytes = beat_bytes + BEAT_W'(s_axis_tstrb[i]);
        end
        len_sum = {1'b0, len_q} + 17'(beat_bytes);
        len_acc = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end

    // DROP swallows beats unconditionally; otherwise accept only when the output slot frees up.
    always_comb begin
        s_ready = 1'b0;
        if (!axi_reset) begin
            s_ready = (state_q == DROP) ? 1'b1 : (!m_tvalid_q || m_axis_tready);
        end
        s_fire    = s_axis_tvalid && s_ready;
        fwd       = s_fire && ((state_q == PASS) || ((state_q == SOF) && gate_en));
        drop_beat = s_fire && !fwd;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        m_tdata_d  = m_tdata_q;
        m_tstrb_d  = m_tstrb_q;
        m_tuser_d  = m_tuser_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        pkt_d      = pkt_q;
        byte_d     = byte_q;
        drop_d     = drop_q;
        max_d      = max_q;

        if (s_fire) begin
            case (state_q)
                SOF:     if (!s_axis_tlast) state_d = gate_en ? PASS : DROP;
                default: if (s_axis_tlast)  state_d = SOF;
            endcase
        end

        if (fwd) begin
            len_d      = s_axis_tlast ? 16'd0 : len_acc;
            m_tdata_d  = s_axis_tdata;
            m_tstrb_d  = s_axis_tstrb;
            m_tuser_d  = s_axis_tuser;
            m_tlast_d  = s_axis_tlast;
            m_tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (fwd && s_axis_tlast) begin
            pkt_d  = pkt_q + CNT_W'(1);
            byte_d = byte_q + BYTE_W'(len_acc);
            if (len_acc > max_q) max_d = len_acc;
        end
        if (drop_beat && s_axis_tlast) begin
            drop_d = drop_q + CNT_W'(1);
        end

        // Clearing wins over any update in the same cycle but leaves packet tracking alone.
        if (clear_stats) begin
            pkt_d  = '0;
            byte_d = '0;
            drop_d = '0;
            max_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= SOF;
            len_q      <= '0;
            m_tdata_q  <= '0;
            m_tstrb_q  <= '0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            pkt_q      <= '0;
            byte_q     <= '0;
            drop_q     <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            m_tdata_q  <= m_tdata_d;
            m_tstrb_q  <= m_tstrb_d;
            m_tuser_q  <= m_tuser_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            pkt_q      <= pkt_d;
            byte_q     <= byte_d;
            drop_q     <= drop_d;
            max_q      <= max_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tstrb  = m_tstrb_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign pkt_count     = pkt_q;
    assign byte_count    = byte_q;
    assign drop_count    = drop_q;
    assign max_pkt_len   = max_q;

endmodule

// File: tb/tb_tx_stream_gate_stats.sv
// Directed bench for tx_stream_gate_stats: forwarding, dropping, backpressure,
// clear priority and mid-packet reset, with hand-computed statistics.
module tb_tx_stream_gate_stats;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;

    logic            clk = 1'b0;
    logic            axi_reset;
    logic [DW-1:0]   s_axis_tdata;
    logic [SW-1:0]   s_axis_tstrb;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [SW-1:0]   m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            gate_en;
    logic            clear_stats;
    logic [31:0]     pkt_count;
    logic [63:0]     byte_count;
    logic [31:0]     drop_count;
    logic [15:0]     max_pkt_len;

    always #5 clk = ~clk;

    tx_stream_gate_stats dut (
        .axi_aclk      (clk),
        .axi_reset     (axi_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .gate_en       (gate_en),
        .clear_stats   (clear_stats),
        .pkt_count     (pkt_count),
        .byte_count    (byte_count),
        .drop_count    (drop_count),
        .max_pkt_len   (max_pkt_len)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] out_data[$];
    logic [SW-1:0] out_strb[$];
    logic [UW-1:0] out_user[$];
    logic          out_last[$];
    int            valid_cycles = 0;
    int            stall_checks = 0;
    logic          prev_stall   = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    bit            toggle_en    = 1'b0;

    // Output monitor: records master transfers and checks that stalled beats hold steady.
    always @(negedge clk) begin
        if (prev_stall) begin
            vectors++;
            stall_checks++;
            assert (m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data) else begin
                miscompares++;
                $error("FAIL stall_hold: observed valid=%0b data=%0h expected valid=1 data=%0h",
                       m_axis_tvalid, m_axis_tdata, prev_data);
            end
        end
        if (m_axis_tvalid === 1'b1) valid_cycles++;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            out_data.push_back(m_axis_tdata);
            out_strb.push_back(m_axis_tstrb);
            out_user.push_back(m_axis_tuser);
            out_last.push_back(m_axis_tlast);
        end
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0) && !axi_reset;
        prev_data  = m_axis_tdata;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) m_axis_tready = ~m_axis_tready;
    endtask

    // Presents one beat and returns one step after the edge on which it was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic [UW-1:0] u, input logic l);
        bit acc;
        int n;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            #1;
            acc = s_axis_tready;
            tick();
            n++;
        end
        s_axis_tvalid = 1'b0;
        if (!acc) chk("send_timeout", 256'(acc), 256'(1));
    endtask

    task automatic chk_stats(input string tag, input int pkt, input longint bytes,
                             input int drop, input int maxl);
        chk({tag, "_pkt"},  256'(pkt_count),   256'(pkt));
        chk({tag, "_byte"}, 256'(byte_count),  256'(bytes));
        chk({tag, "_drop"}, 256'(drop_count),  256'(drop));
        chk({tag, "_max"},  256'(max_pkt_len), 256'(maxl));
    endtask

    function automatic logic [DW-1:0] mkd(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + i;
        return {8{w}};
    endfunction

    function automatic logic [UW-1:0] mku(input int i);
        logic [31:0] w;
        w = 32'h5500_0000 + i;
        return {4{w}};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, vb, sc0;
        logic [SW-1:0] es;

        axi_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        gate_en       = 1'b1;
        clear_stats   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_s_ready", 256'(s_axis_tready), 256'(0));
        chk("rst_m_valid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_m_last",  256'(m_axis_tlast),  256'(0));
        chk("rst_m_data",  m_axis_tdata,        256'(0));
        chk_stats("rst", 0, 0, 0, 0);
        axi_reset = 1'b0;
        #1;
        chk("post_rst_s_ready", 256'(s_axis_tready), 256'(1));

        // Three 2-beat forwarded packets of 32 + 16 bytes
        base = out_data.size();
        for (int p = 0; p < 3; p++) begin
            send_beat(mkd(2*p), '1, mku(2*p), 1'b0);
            if (p == 0) begin
                chk("latency_valid", 256'(m_axis_tvalid), 256'(1));
                chk("latency_data",  m_axis_tdata,        mkd(0));
            end
            send_beat(mkd(2*p+1), 32'h0000_FFFF, mku(2*p+1), 1'b1);
        end
        repeat (3) tick();
        chk("fwd_beats", 256'(out_data.size() - base), 256'(6));
        for (int i = 0; i < 6; i++) begin
            if (out_data.size() > base + i) begin
                es = (i % 2 == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
                chk("fwd_data", out_data[base+i],      mkd(i));
                chk("fwd_strb", 256'(out_strb[base+i]), 256'(es));
                chk("fwd_user", 256'(out_user[base+i]), 256'(mku(i)));
                chk("fwd_last", 256'(out_last[base+i]), 256'(i % 2));
            end
        end
        chk_stats("fwd", 3, 144, 0, 48);

        // gate_en low at SOF, raised mid-packet: whole 4-beat packet dropped
        base = out_data.size();
        vb   = valid_cycles;
        gate_en = 1'b0;
        send_beat(mkd(100), '1, mku(100), 1'b0);
        gate_en = 1'b1;
        send_beat(mkd(101), '1, mku(101), 1'b0);
        send_beat(mkd(102), '1, mku(102), 1'b0);
        send_beat(mkd(103), '1, mku(103), 1'b1);
        repeat (2) tick();
        chk("drop_no_valid", 256'(valid_cycles - vb), 256'(0));
        chk("drop_no_beats", 256'(out_data.size() - base), 256'(0));
        chk_stats("drop", 3, 144, 1, 48);

        // 5-beat packet under alternating backpressure: 4*32 + 1 = 129 bytes
        base = out_data.size();
        sc0  = stall_checks;
        m_axis_tready = 1'b1;
        toggle_en     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_beat(mkd(10+i), (i == 4) ? 32'h1 : '1, mku(10+i), i == 4);
        end
        for (int n = 0; n < 20 && out_data.size() < base + 5; n++) tick();
        toggle_en     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("bp_beats", 256'(out_data.size() - base), 256'(5));
        for (int i = 0; i < 5; i++) begin
            if (out_data.size() > base + i) begin
                chk("bp_data", out_data[base+i],      mkd(10+i));
                chk("bp_last", 256'(out_last[base+i]), 256'(i == 4));
            end
        end
        chk("bp_stall_seen", 256'(stall_checks > sc0), 256'(1));
        chk_stats("bp", 4, 273, 1, 129);

        // clear_stats on the forwarded tlast beat wins over that update
        send_beat(mkd(20), '1, mku(20), 1'b0);
        clear_stats = 1'b1;
        send_beat(mkd(21), '1, mku(21), 1'b1);
        clear_stats = 1'b0;
        chk_stats("clr", 0, 0, 0, 0);

        // Zero-strobe beat contributes nothing; FSM still tracks packets after clear
        send_beat(mkd(22), '0, mku(22), 1'b0);
        send_beat(mkd(23), 32'hF, mku(23), 1'b1);
        tick();
        chk_stats("zstrb", 1, 4, 0, 4);

        // Reset on beat 2 of a 3-beat packet, then a fresh 1-byte single-beat packet
        send_beat(mkd(30), '1, mku(30), 1'b0);
        s_axis_tdata  = mkd(31);
        s_axis_tstrb  = '1;
        s_axis_tuser  = mku(31);
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        axi_reset     = 1'b1;
        tick();
        chk("mrst_s_ready", 256'(s_axis_tready), 256'(0));
        chk("mrst_m_valid", 256'(m_axis_tvalid), 256'(0));
        tick();
        axi_reset     = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        send_beat(mkd(40), 32'h1, mku(40), 1'b1);
        chk("mrst_out_valid", 256'(m_axis_tvalid), 256'(1));
        chk("mrst_out_data",  m_axis_tdata,        mkd(40));
        tick();
        chk_stats("mrst", 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
